// File: rtl/dff_arb_pkg.sv
// Shared types and helpers for the round-robin D flip-flop arbiter.
package dff_arb_pkg;

    // Sequencer states: IDLE arbitrates, LOAD lets the register sample ff_d,
    // CAPT reads the register back and issues the response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CAPT = 2'd2
    } arb_state_t;

    // Widest request vector the reference picker function accepts.
    localparam int MAX_REQ = 32;

    // Reference round-robin pick: returns the first valid index at or above
    // ptr, wrapping modulo num. Returns ptr when nothing is valid.
    function automatic int unsigned rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int unsigned        ptr,
        input int unsigned        num
    );
        int unsigned idx;
        bit          found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < num && !found) begin
                idx = ptr + i;
                if (idx >= num) begin
                    idx = idx - num;
                end
                if (valid[idx]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/dff_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so the
// priority pointer sits at bit 0, take the lowest set bit, rotate the
// result back into absolute requester numbering.
module rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any_valid
);
    import dff_arb_pkg::*;

    logic [NUM_REQ-1:0] w_rot;
    logic [ID_W-1:0]    w_enc;
    logic [ID_W:0]      w_sum;
    int                 w_src;

    // Rotate, priority-encode in rotated space, then map back to an absolute index.
    always_comb begin
        w_rot       = '0;
        w_enc       = '0;
        w_sum       = '0;
        w_src       = 0;
        o_grant     = '0;
        o_idx       = '0;
        o_any_valid = |i_valid;

        for (int i = 0; i < NUM_REQ; i++) begin
            w_src = i + int'(i_ptr);
            if (w_src >= NUM_REQ) begin
                w_src = w_src - NUM_REQ;
            end
            w_rot[i] = i_valid[w_src];
        end

        // Scan downward so the lowest set bit in rotated order wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_enc = ID_W'(i);
            end
        end

        w_sum = {1'b0, w_enc} + {1'b0, i_ptr};
        if (w_sum >= (ID_W + 1)'(NUM_REQ)) begin
            w_sum = w_sum - (ID_W + 1)'(NUM_REQ);
        end
        o_idx = w_sum[ID_W-1:0];

        for (int i = 0; i < NUM_REQ; i++) begin
            o_grant[i] = o_any_valid && (o_idx == ID_W'(i));
        end
    end

endmodule

// File: rtl/dff_rr_arbiter.sv
// Round-robin front end for a single external D flip-flop register.
// Each accepted request writes the register, reads it back two cycles
// later and returns the read value with a mismatch flag.
module dff_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         ff_d,
    input  logic [DATA_W-1:0]         ff_q,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic                      busy
);
    import dff_arb_pkg::*;

    arb_state_t          r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_cur_id;
    logic [DATA_W-1:0]   r_ff_d;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;

    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_win_idx;
    logic                w_any_valid;
    logic [DATA_W-1:0]   w_win_data;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [ID_W:0]       w_ptr_sum;
    logic                w_accept;

    rr_picker #(
        .NUM_REQ     (NUM_REQ)
    ) u_picker (
        .i_valid     (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_idx       (w_win_idx),
        .o_any_valid (w_any_valid)
    );

    // Grant gating, winner data mux and next priority pointer.
    always_comb begin
        w_accept   = (r_state == IDLE) && w_any_valid;
        req_ready  = (r_state == IDLE) ? w_grant : '0;
        busy       = (r_state != IDLE);

        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == ID_W'(i)) begin
                w_win_data = req_data[i*DATA_W +: DATA_W];
            end
        end

        // Pointer moves one past the winner so it drops to lowest priority.
        w_ptr_sum = {1'b0, w_win_idx} + (ID_W + 1)'(1);
        if (w_ptr_sum >= (ID_W + 1)'(NUM_REQ)) begin
            w_ptr_sum = '0;
        end
        w_ptr_nxt = w_ptr_sum[ID_W-1:0];
    end

    // Sequencer, register write path and response capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_cur_id    <= '0;
            r_ff_d      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ff_d   <= w_win_data;
                        r_cur_id <= w_win_idx;
                        r_rr_ptr <= w_ptr_nxt;
                        r_state  <= LOAD;
                    end
                end
                LOAD: begin
                    r_state <= CAPT;
                end
                CAPT: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_cur_id;
                    r_rsp_data  <= ff_q;
                    r_rsp_err   <= (ff_q != r_ff_d);
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ff_d      = r_ff_d;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dff_rr_arbiter.sv
// Directed bench for dff_rr_arbiter with a behavioural external register.
module tb_dff_rr_arbiter;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [7:0]  ff_d;
    logic [7:0]  ff_q;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        busy;

    logic [7:0]  reg_q;
    logic        q_force;

    int n_chk  = 0;
    int n_fail = 0;

    dff_rr_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ff_d      (ff_d),
        .ff_q      (ff_q),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External D flip-flop register shared by the requesters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) reg_q <= 8'h00;
        else          reg_q <= ff_d;
    end

    assign ff_q = q_force ? 8'h00 : reg_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        nedge();
        nedge();
        reset_n = 1'b1;
        nedge();
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 4'b0000;
        req_data  = 32'h0;
        q_force   = 1'b0;
        nedge();
        nedge();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_ff_d", ff_d, 0);
        chk("rst_ready", req_ready, 0);
        reset_n = 1'b1;
        nedge();

        // Test 1: single write of A5 from requester 0
        req_data[7:0] = 8'hA5;
        req_valid     = 4'b0001;
        #1;
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_busy_idle", busy, 0);
        nedge();
        chk("t1_ff_d", ff_d, 8'hA5);
        chk("t1_busy_load", busy, 1);
        chk("t1_ready_load", req_ready, 4'b0000);
        req_valid = 4'b0000;
        nedge();
        chk("t1_no_rsp_capt", rsp_valid, 0);
        nedge();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_data", rsp_data, 8'hA5);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_busy_done", busy, 0);
        nedge();
        chk("t1_rsp_pulse", rsp_valid, 0);
        chk("t1_rsp_hold", rsp_data, 8'hA5);
        chk("t1_ff_d_hold", ff_d, 8'hA5);

        // Test 2: all requesters continuously valid, order 0,1,2,3,0
        do_reset();
        req_data  = 32'h13121110;
        req_valid = 4'b1111;
        #1;
        begin
            logic [1:0] order [5];
            order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
            for (int k = 0; k < 5; k++) begin
                chk("t2_grant", req_ready, 32'h1 << order[k]);
                nedge();
                chk("t2_ff_d", ff_d, 8'h10 + order[k]);
                nedge();
                nedge();
                chk("t2_rsp_valid", rsp_valid, 1);
                chk("t2_rsp_id", rsp_id, order[k]);
                chk("t2_rsp_data", rsp_data, 8'h10 + order[k]);
            end
        end
        req_valid = 4'b0000;
        nedge();

        // Test 3: grant to 1 leaves pointer at 2, then 0 and 1 compete
        req_valid = 4'b0010;
        #1;
        chk("t3_grant1", req_ready, 4'b0010);
        nedge();
        req_valid = 4'b0000;
        nedge();
        nedge();
        chk("t3_rsp1_id", rsp_id, 1);
        req_valid = 4'b0011;
        #1;
        chk("t3_wrap_grant0", req_ready, 4'b0001);
        nedge();
        nedge();
        nedge();
        chk("t3_rsp0_id", rsp_id, 0);
        chk("t3_rsp0_data", rsp_data, 8'h10);
        chk("t3_then_grant1", req_ready, 4'b0010);
        nedge();
        req_valid = 4'b0000;
        nedge();
        nedge();
        chk("t3_rsp1b_id", rsp_id, 1);
        chk("t3_rsp1b_data", rsp_data, 8'h11);

        // Test 4: register reads back 00 after a write of FF
        req_data[23:16] = 8'hFF;
        req_valid       = 4'b0100;
        #1;
        chk("t4_grant", req_ready, 4'b0100);
        nedge();
        req_valid = 4'b0000;
        chk("t4_ff_d", ff_d, 8'hFF);
        nedge();
        q_force = 1'b1;
        nedge();
        q_force = 1'b0;
        chk("t4_rsp_valid", rsp_valid, 1);
        chk("t4_rsp_id", rsp_id, 2);
        chk("t4_rsp_data", rsp_data, 8'h00);
        chk("t4_rsp_err", rsp_err, 1);

        // Test 5: reset during LOAD drops the transaction
        nedge();
        req_data[15:8] = 8'h3C;
        req_valid      = 4'b0010;
        #1;
        chk("t5_grant", req_ready, 4'b0010);
        nedge();
        req_valid = 4'b0000;
        chk("t5_busy_load", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_busy_rst", busy, 0);
        chk("t5_ff_d_rst", ff_d, 0);
        chk("t5_rsp_valid_rst", rsp_valid, 0);
        chk("t5_rsp_id_rst", rsp_id, 0);
        chk("t5_rsp_data_rst", rsp_data, 0);
        chk("t5_rsp_err_rst", rsp_err, 0);
        chk("t5_ready_rst", req_ready, 0);
        nedge();
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nedge();
            chk("t5_no_rsp", rsp_valid, 0);
        end
        req_valid = 4'b1010;
        #1;
        chk("t5_lowest_first", req_ready, 4'b0010);
        nedge();
        req_valid = 4'b0000;
        nedge();
        nedge();
        chk("t5_rsp_id", rsp_id, 1);
        chk("t5_rsp_data", rsp_data, 8'h3C);

        // Test 6: requester 3 alone, back-to-back writes 00, FF, 5A
        nedge();
        req_data[31:24] = 8'h00;
        req_valid       = 4'b1000;
        #1;
        chk("t6_grant_a", req_ready, 4'b1000);
        nedge();
        req_data[31:24] = 8'hFF;
        nedge();
        nedge();
        chk("t6_rsp_a_valid", rsp_valid, 1);
        chk("t6_rsp_a", {rsp_id, rsp_err, rsp_data}, {2'd3, 1'b0, 8'h00});
        chk("t6_grant_b", req_ready, 4'b1000);
        nedge();
        chk("t6_pulse_a", rsp_valid, 0);
        req_data[31:24] = 8'h5A;
        nedge();
        nedge();
        chk("t6_rsp_b_valid", rsp_valid, 1);
        chk("t6_rsp_b", {rsp_id, rsp_err, rsp_data}, {2'd3, 1'b0, 8'hFF});
        chk("t6_grant_c", req_ready, 4'b1000);
        nedge();
        req_valid = 4'b0000;
        nedge();
        nedge();
        chk("t6_rsp_c_valid", rsp_valid, 1);
        chk("t6_rsp_c", {rsp_id, rsp_err, rsp_data}, {2'd3, 1'b0, 8'h5A});
        nedge();
        chk("t6_idle_after", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
